// File: rtl/gate_share_arbiter_if.sv
// Bundle between the requesters (master side) and the shared gate evaluator
// arbiter (slave side). fsm_state mirrors the arbiter state for observation.
interface gate_share_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = $clog2(NREQ)
);
   logic [NREQ-1:0]       req;
   logic [2*NREQ-1:0]     op;
   logic [WIDTH*NREQ-1:0] a;
   logic [WIDTH*NREQ-1:0] b;
   logic [NREQ-1:0]       gnt;
   logic                  busy;
   logic                  res_valid;
   logic [IDW-1:0]        res_id;
   logic [WIDTH-1:0]      res;
   logic [1:0]            fsm_state;

   // Handshake: a requester holds req high until it sees its own gnt bit
   // (a one-cycle pulse); its op/a/b are captured on the granting edge, so it
   // may change them or drop req afterwards. res_valid is a one-cycle pulse
   // qualifying res/res_id, which then hold until the next result.
   modport master (
      output req, op, a, b,
      input  gnt, busy, res_valid, res_id, res, fsm_state
   );

   modport slave (
      input  req, op, a, b,
      output gnt, busy, res_valid, res_id, res, fsm_state
   );
endinterface

// File: rtl/gate_share_arbiter.sv
// Shares one WIDTH-bit NOT/AND/OR/XOR unit among NREQ requesters (round-robin).
// Define GATE_SHARE_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module gate_share_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = $clog2(NREQ)
) (
   input logic                  clk,
   input logic                  rst_n,
   gate_share_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [IDW-1:0]   cur_id;
   logic [1:0]       cap_op;
   logic [WIDTH-1:0] cap_a;
   logic [WIDTH-1:0] cap_b;

   logic             win_found;
   logic [IDW-1:0]   win_id;
   logic [IDW-1:0]   idx;
   logic [1:0]       win_op;
   logic [WIDTH-1:0] win_a;
   logic [WIDTH-1:0] win_b;

`ifndef GATE_SHARE_ARB_FIXED_PRIO_EN
   logic [IDW-1:0]   rr_ptr;
`endif

   assign bus.fsm_state = state;

   // First set req bit, scanning upward from the search start with wrap;
   // NREQ is a power of two so IDW-bit addition wraps for free.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      idx       = '0;
      for (int k = 0; k < NREQ; k++) begin
`ifdef GATE_SHARE_ARB_FIXED_PRIO_EN
         idx = IDW'(k);
`else
         idx = rr_ptr + IDW'(k);
`endif
         if (!win_found && bus.req[idx]) begin
            win_found = 1'b1;
            win_id    = idx;
         end
      end
   end

   // Only the winner's slices are selected, so X/Z elsewhere cannot leak in.
   assign win_op = bus.op[2*win_id +: 2];
   assign win_a  = bus.a[WIDTH*win_id +: WIDTH];
   assign win_b  = bus.b[WIDTH*win_id +: WIDTH];

   function automatic logic [WIDTH-1:0] gate_eval(
      input logic [1:0]       o,
      input logic [WIDTH-1:0] x,
      input logic [WIDTH-1:0] y
   );
      case (o)
         2'b00:   gate_eval = ~x;
         2'b01:   gate_eval = x & y;
         2'b10:   gate_eval = x | y;
         default: gate_eval = x ^ y;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         bus.gnt       <= '0;
         bus.busy      <= 1'b0;
         bus.res_valid <= 1'b0;
         bus.res_id    <= '0;
         bus.res       <= '0;
         cur_id        <= '0;
         cap_op        <= '0;
         cap_a         <= '0;
         cap_b         <= '0;
`ifndef GATE_SHARE_ARB_FIXED_PRIO_EN
         rr_ptr        <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  cur_id   <= win_id;
                  cap_op   <= win_op;
                  cap_a    <= win_a;
                  cap_b    <= win_b;
                  bus.gnt  <= NREQ'(1) << win_id;
                  bus.busy <= 1'b1;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               bus.res       <= gate_eval(cap_op, cap_a, cap_b);
               bus.res_id    <= cur_id;
               bus.res_valid <= 1'b1;
               bus.gnt       <= '0;
               state         <= DONE;
            end
            DONE: begin
               bus.res_valid <= 1'b0;
               bus.busy      <= 1'b0;
`ifndef GATE_SHARE_ARB_FIXED_PRIO_EN
               rr_ptr        <= cur_id + IDW'(1);
`endif
               state         <= IDLE;
            end
            default: begin
               bus.gnt       <= '0;
               bus.busy      <= 1'b0;
               bus.res_valid <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_share_arbiter.sv
// Bench for gate_share_arbiter: transaction-level model of arbitration order
// and gate results, with a result scoreboard fed from an expected queue.
module tb_gate_share_arbiter;
   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int IDW   = $clog2(NREQ);

   logic clk;
   logic rst_n;

   gate_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

   gate_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [NREQ-1:0]  pend;
   logic [1:0]       t_op [NREQ];
   logic [WIDTH-1:0] t_a  [NREQ];
   logic [WIDTH-1:0] t_b  [NREQ];
   int               m_ptr;
   int               total;
   int               bad;
   logic [IDW+WIDTH-1:0] exp_q [$];

   // Requester slices that are not requesting are driven to X.
   always_comb begin
      bus.req = pend;
      bus.op  = '0;
      bus.a   = '0;
      bus.b   = '0;
      for (int i = 0; i < NREQ; i++) begin
         bus.op[2*i +: 2]         = pend[i] ? t_op[i] : 2'bxx;
         bus.a[WIDTH*i +: WIDTH]  = pend[i] ? t_a[i]  : {WIDTH{1'bx}};
         bus.b[WIDTH*i +: WIDTH]  = pend[i] ? t_b[i]  : {WIDTH{1'bx}};
      end
   end

   function automatic int model_pick(input logic [NREQ-1:0] r, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [WIDTH-1:0] model_op(input logic [1:0] o,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
      if (o == 2'd0) return ~x;
      if (o == 2'd1) return x & y;
      if (o == 2'd2) return x | y;
      return x ^ y;
   endfunction

   // Scoreboard: every res_valid pulse must match the oldest expected result.
   always @(negedge clk) begin
      logic [IDW+WIDTH-1:0] e;
      if (bus.res_valid === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got id=%0d res=%h, no result expected",
                     bus.res_id, bus.res);
         end else begin
            e = exp_q.pop_front();
            if ({bus.res_id, bus.res} !== e) begin
               bad++;
               $display("FAIL sb_result: got id=%0d res=%h, want id=%0d res=%h",
                        bus.res_id, bus.res, e[IDW+WIDTH-1:WIDTH], e[WIDTH-1:0]);
            end
         end
      end
   end

   task automatic randomize_operands(input int i);
      t_op[i] = 2'($urandom_range(0, 3));
      t_a[i]  = WIDTH'($urandom);
      t_b[i]  = WIDTH'($urandom);
   endtask

   // Called at a negedge with the DUT idle and pend != 0; runs one full grant.
   task automatic serve_one(input bit hold, input bit scramble);
      int               id;
      logic [WIDTH-1:0] r;
      logic [NREQ-1:0]  eg;
      id = model_pick(pend, m_ptr);
      r  = model_op(t_op[id], t_a[id], t_b[id]);
      eg = '0;
      eg[id] = 1'b1;
      @(negedge clk);
      total++;
      if (bus.gnt !== eg || bus.busy !== 1'b1 || bus.res_valid !== 1'b0) begin
         bad++;
         $display("FAIL grant: got gnt=%b busy=%b rv=%b, want gnt=%b busy=1 rv=0",
                  bus.gnt, bus.busy, bus.res_valid, eg);
      end
      exp_q.push_back({IDW'(id), r});
      if (!hold) pend[id] = 1'b0;
      if (scramble) randomize_operands(id);
      @(negedge clk);
      total++;
      if (bus.res_valid !== 1'b1 || bus.gnt !== '0 || bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL exec: got rv=%b gnt=%b busy=%b, want rv=1 gnt=0 busy=1",
                  bus.res_valid, bus.gnt, bus.busy);
      end
      @(negedge clk);
      total++;
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.res !== r ||
          bus.res_id !== IDW'(id)) begin
         bad++;
         $display("FAIL done_hold: got rv=%b busy=%b id=%0d res=%h, want rv=0 busy=0 id=%0d res=%h",
                  bus.res_valid, bus.busy, bus.res_id, bus.res, id, r);
      end
`ifndef GATE_SHARE_ARB_FIXED_PRIO_EN
      m_ptr = (id + 1) % NREQ;
`endif
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      pend  = '1;
      for (int i = 0; i < NREQ; i++) randomize_operands(i);
      repeat (3) begin
         @(negedge clk);
         total++;
         if (bus.gnt !== '0 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0 ||
             bus.res !== '0 || bus.res_id !== '0) begin
            bad++;
            $display("FAIL reset_state: got gnt=%b busy=%b rv=%b id=%0d res=%h, want all zero",
                     bus.gnt, bus.busy, bus.res_valid, bus.res_id, bus.res);
         end
      end
      rst_n = 1'b1;
      m_ptr = 0;
      while (pend != '0) serve_one(1'b0, 1'b1);
   endtask

   task automatic test_single_not();
      pend    = 4'b0100;
      t_op[2] = 2'b00;
      t_a[2]  = 8'h0F;
      t_b[2]  = 8'h5A;
      total++;
      if (model_op(t_op[2], t_a[2], t_b[2]) !== 8'hF0) begin
         bad++;
         $display("FAIL not_model: got %h want f0", model_op(t_op[2], t_a[2], t_b[2]));
      end
      serve_one(1'b0, 1'b0);
   endtask

   task automatic test_round_robin();
      pend = '1;
      for (int i = 0; i < NREQ; i++) begin
         t_op[i] = 2'b01;
         t_a[i]  = 8'hFF;
         t_b[i]  = WIDTH'(i);
      end
      repeat (2 * NREQ) serve_one(1'b1, 1'b0);
      pend = '0;
   endtask

   task automatic test_wrap_skip();
      pend = 4'b1000;
      randomize_operands(3);
      serve_one(1'b0, 1'b1);
      pend = 4'b1010;
      randomize_operands(1);
      randomize_operands(3);
      repeat (3) serve_one(1'b1, 1'b1);
      pend = '0;
   endtask

   task automatic test_ops();
      for (int k = 0; k < 4; k++) begin
         pend    = 4'b0001;
         t_op[0] = 2'(k);
         t_a[0]  = 8'hCC;
         t_b[0]  = 8'hAA;
         serve_one(1'b0, 1'b0);
      end
   endtask

   task automatic test_mid_reset();
      pend    = 4'b0010;
      t_op[1] = 2'b01;
      t_a[1]  = 8'hFF;
      t_b[1]  = 8'h5A;
      serve_one(1'b0, 1'b0);
      pend = 4'b0100;
      randomize_operands(2);
      @(negedge clk);
      total++;
      if (bus.gnt !== 4'b0100) begin
         bad++;
         $display("FAIL midrst_gnt: got %b want 0100", bus.gnt);
      end
      rst_n = 1'b0;
      pend  = '0;
      #1;
      total++;
      if (bus.gnt !== '0 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.res !== '0) begin
         bad++;
         $display("FAIL midrst_clear: got gnt=%b busy=%b rv=%b res=%h, want zeros",
                  bus.gnt, bus.busy, bus.res_valid, bus.res);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_ptr = 0;
      pend  = 4'b1001;
      randomize_operands(0);
      randomize_operands(3);
      while (pend != '0) serve_one(1'b0, 1'b1);
   endtask

   task automatic test_random();
      for (int it = 0; it < 40; it++) begin
         int guard;
         pend = 4'($urandom_range(1, 15));
         for (int i = 0; i < NREQ; i++) randomize_operands(i);
         guard = 0;
         while (pend != '0 && guard < 12) begin
            serve_one($urandom_range(0, 3) == 0, 1'b1);
            if ($urandom_range(0, 3) == 0) pend = pend & 4'($urandom);
            guard++;
         end
         pend = '0;
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            total++;
            if (bus.gnt !== '0 || bus.busy !== 1'b0) begin
               bad++;
               $display("FAIL idle_gap: got gnt=%b busy=%b, want 0 0", bus.gnt, bus.busy);
            end
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      m_ptr = 0;
      pend  = '0;
      rst_n = 1'b0;
      test_reset();
      test_single_not();
      test_round_robin();
      test_wrap_skip();
      test_ops();
      test_mid_reset();
      test_random();
      repeat (3) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: got %0d results outstanding, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gate_share_arbiter.md
Name: gate_share_arbiter

Overview:
- Shares one bitwise logic unit (NOT/AND/OR/XOR, WIDTH bits) among NREQ requesters.
- Round-robin arbitration with a req/gnt handshake; operands are captured at grant, and the result is returned one cycle later, tagged with the requester id.
- Sits between the gate-level test structures and the single shared gate evaluator, replacing per-requester gate instances.

Parameters:
NREQ, 4, number of requesters; power of two, 2..8
WIDTH, 8, operand/result width in bits
IDW, $clog2(NREQ), requester id width (derived; do not override)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester request; held high until own gnt bit seen
op  input  2*NREQ  per-requester opcode, slice i = op[2i+1:2i]; 00 NOT a, 01 AND, 10 OR, 11 XOR
a  input  WIDTH*NREQ  per-requester operand A, slice i
b  input  WIDTH*NREQ  per-requester operand B, slice i (ignored for NOT)
gnt  output  NREQ  one-hot grant, 1-cycle pulse
busy  output  1  high whenever state != IDLE
res_valid  output  1  1-cycle pulse, res/res_id valid
res_id  output  IDW  index of requester owning res
res  output  WIDTH  operation result

Behaviour:
- Reset (async assert, sync-released by clk domain): state=IDLE, gnt=0, busy=0, res_valid=0, res_id=0, res=0, rr_ptr=0, captured op/operands=0.
- FSM states and transitions:
  - IDLE:
    - If req==0, stay.
    - Otherwise select the first set req bit, searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...).
    - On that edge: capture op/a/b of the winner and its id, drive gnt=onehot(id), go EXEC.
  - EXEC (gnt high this cycle):
    - On edge: res <= f(op, a, b), res_id <= id, res_valid <= 1, gnt <= 0, go DONE.
  - DONE (res_valid high this cycle):
    - On edge: res_valid <= 0, rr_ptr <= (id+1) mod NREQ, go IDLE.
- Latency and throughput:
  - req sampled high in IDLE at edge N: gnt high in cycle N..N+1, res_valid high in cycle N+1..N+2.
  - Throughput is one grant per 3 cycles; no new arbitration in EXEC or DONE.
- Handshake:
  - A requester may change its op/a/b and deassert req in the cycle after its gnt; its values are already captured.
  - req still high in DONE counts as a new request in the next IDLE arbitration.
  - Deasserting req before gnt withdraws the request without error.
- Result:
  - NOT yields ~a; b is ignored.
  - Other ops are bitwise over the full WIDTH; no carry or sign.
  - res and res_id hold their value after res_valid falls until the next EXEC edge.
- Fairness:
  - rr_ptr advances past the last winner only.
  - With all req high, grant order is 0,1,2,3,0,...
  - A lone requester is granted every 3 cycles.
- Boundary conditions:
  - rr_ptr=NREQ-1 wraps to 0.
  - Simultaneous req from all requesters resolves purely by rr_ptr.
  - Reset asserted in EXEC or DONE aborts the operation: no res_valid pulse, res cleared, rr_ptr=0.
  - X/Z on unrequested slices has no effect on outputs.

Optional Feature:
- Macro: GATE_SHARE_ARB_FIXED_PRIO_EN.
- Defined: fixed priority replaces round-robin. The lowest-index set req bit always wins; rr_ptr is not implemented (no register). Grant order with all req high is 0,0,0,...
- Undefined: round-robin as specified above.
- Timing, handshake and reset behaviour are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 -> gnt=0, busy=0, res_valid=0, res=0; first grant after release goes to requester 0.
- Single NOT: req=4'b0100, op slice2=00, a slice2=8'h0F -> gnt=4'b0100 one cycle later; next cycle res_valid=1, res_id=2, res=8'hF0; busy low again after 3 cycles.
- Round-robin: req=4'b1111 held 12 cycles, op AND, a=8'hFF, b slice i=i -> gnt sequence 0001,0010,0100,1000 at 3-cycle spacing; res = 00,01,02,03 with matching res_id.
- Wrap and skip: after a grant to 3, req=4'b1010 -> grant 1, then 3, then 1.
- Ops: requester 0 issues AND/OR/XOR with a=8'hCC, b=8'hAA -> res 8'h88, 8'hEE, 8'h66.
- Mid-op reset: pulse rst_n low during EXEC -> no res_valid, res=0, and the next grant for req=4'b1001 goes to 0.
- Fixed-priority build: run the round-robin test -> gnt stays 4'b0001 every grant.
